fp_mult_result_buffer: RTL and testbench

FP_MULT_RESULT_BUFFER -- requirements
Module: fp_mult_result_buffer

---
 rtl/fp_mult_result_buffer.sv | 67 ++++++
 tb/tb_fp_mult_result_buffer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fp_mult_result_buffer.sv
// fp_mult_result_buffer: FIFO for multiplier products with sticky status flags and a saturating exception counter.
module fp_mult_result_buffer #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              z_in,
  input  logic [7:0]               status_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              z_out,
  output logic [7:0]               status_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               flag_accum,
  input  logic                     flag_clr,
  output logic [EXC_W-1:0]         exc_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    ONE_P = 1;
  localparam logic [AW:0]      ONE_O = 1;
  localparam logic [AW:0]      FULL  = DEPTH;
  localparam logic [EXC_W-1:0] ONE_E = 1;
  logic [39:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      occ_q, occ_d;
  logic [7:0]       flag_q, flag_d;
  logic [EXC_W-1:0] exc_q, exc_d, exc_base;
  logic             push, pop;
  assign in_ready   = occ_q < FULL;
  assign out_valid  = occ_q != '0;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign {status_out, z_out} = mem_q[rd_q];
  assign occupancy  = occ_q;
  assign flag_accum = flag_q;
  assign exc_count  = exc_q;
  always_comb begin
    wr_d     = push ? wr_q + ONE_P : wr_q;
    rd_d     = pop ? rd_q + ONE_P : rd_q;
    occ_d    = (push && !pop) ? occ_q + ONE_O : ((pop && !push) ? occ_q - ONE_O : occ_q);
    flag_d   = (flag_clr ? 8'h00 : flag_q) | (push ? status_in : 8'h00);
    exc_base = flag_clr ? '0 : exc_q;
    exc_d    = (push && status_in != 8'h00 && exc_base != '1) ? exc_base + ONE_E : exc_base;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      flag_q <= '0;
      exc_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      flag_q <= flag_d;
      exc_q  <= exc_d;
    end
  end
  // Storage needs no reset: entries are only visible while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {status_in, z_in};
  end
endmodule

// File: tb/tb_fp_mult_result_buffer.sv
// tb_fp_mult_result_buffer: queue-based reference model checked every cycle, plus literal scenario checks.
module tb_fp_mult_result_buffer;
  localparam int DEPTH = 4;
  localparam int EXC_W = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, flag_clr;
  logic [31:0] z_in, z_out;
  logic [7:0] status_in, status_out, flag_accum;
  logic [$clog2(DEPTH):0] occupancy;
  logic [EXC_W-1:0] exc_count;
  int checks = 0;
  int errors = 0;
  logic [39:0] m_q[$];
  logic [7:0] m_flag;
  int m_exc;

  fp_mult_result_buffer #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z_in(z_in), .status_in(status_in), .out_valid(out_valid),
    .out_ready(out_ready), .z_out(z_out), .status_out(status_out),
    .occupancy(occupancy), .flag_accum(flag_accum), .flag_clr(flag_clr),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("z_out", z_out, m_q[0][31:0]);
      chk("status_out", 32'(status_out), 32'(m_q[0][39:32]));
    end
    chk("flag_accum", 32'(flag_accum), 32'(m_flag));
    chk("exc_count", 32'(exc_count), 32'(m_exc));
  endtask

  task automatic model_step();
    bit push, pop;
    if (rst) begin
      m_q.delete();
      m_flag = 8'h00;
      m_exc = 0;
    end else begin
      push = in_valid && (m_q.size() < DEPTH);
      pop = out_ready && (m_q.size() != 0);
      if (flag_clr) begin
        m_flag = 8'h00;
        m_exc = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({status_in, z_in});
        m_flag = m_flag | status_in;
        if (status_in != 0 && m_exc < (1 << EXC_W) - 1) m_exc++;
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] z, input logic [7:0] st,
                       input logic ordy, input logic clr, input logic r);
    in_valid = iv; z_in = z; status_in = st; out_ready = ordy; flag_clr = clr; rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    m_flag = 8'h00;
    m_exc = 0;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("reset_occ", 32'(occupancy), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    // Single push into empty buffer
    cycle(1, 32'h3F800000, 8'h00, 0, 0, 0);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_z", z_out, 32'h3F800000);
    chk("single_occ", 32'(occupancy), 1);
    chk("single_exc", 32'(exc_count), 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Overfill then drain
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h100 + i, 8'h00, 0, 0, 0);
      if (i == 3) chk("full_in_ready", 32'(in_ready), 0);
    end
    chk("full_occ", 32'(occupancy), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", z_out, 32'h100 + i);
      cycle(0, 0, 0, 1, 0, 0);
    end
    chk("drain_empty", 32'(out_valid), 0);
    // Continuous push+pop across wrap
    cycle(1, 32'hA0, 8'h00, 0, 0, 0);
    cycle(1, 32'hA1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stream_head", z_out, 32'hA0 + i);
      cycle(1, 32'hA2 + i, 8'h00, 1, 0, 0);
      chk("stream_occ", 32'(occupancy), 2);
    end
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Sticky flags and clear-with-push
    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 32'h1, 8'h01, 1, 0, 0);
    cycle(1, 32'h2, 8'h04, 1, 0, 0);
    cycle(1, 32'h3, 8'h00, 1, 0, 0);
    chk("flags_accum", 32'(flag_accum), 32'h05);
    chk("flags_exc", 32'(exc_count), 2);
    cycle(1, 32'h4, 8'h10, 1, 1, 0);
    chk("clr_accum", 32'(flag_accum), 32'h10);
    chk("clr_exc", 32'(exc_count), 1);
    chk("clr_keeps_fifo", 32'(out_valid), 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom(),
            ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'h00,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 199) == 0));
    end
    // Counter saturation
    cycle(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < (1 << EXC_W) + 3; i++)
      cycle(1, $urandom(), 8'h80, 1, 0, 0);
    chk("sat_exc", 32'(exc_count), 32'hFF);
    // Reset mid-operation with push pending
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h200 + i, 8'h02, 0, 0, 0);
    chk("pre_rst_occ", 32'(occupancy), 3);
    cycle(1, 32'h300, 8'h08, 1, 1, 1);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_accum", 32'(flag_accum), 0);
    chk("rst_exc", 32'(exc_count), 0);
    cycle(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
